// File: rtl/mem_access_unit.sv
// MEM stage access unit: drives the data-memory handshake, stalls the pipeline
// while a request is in flight, and owns the MEM/WB register.
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_read_data2,
   input  logic [4:0]  ex_write_reg,
   input  logic        ex_regwrite,
   input  logic        ex_memwrite,
   input  logic        ex_memread,
   input  logic [1:0]  ex_memtoreg,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_alu_result,
   output logic [31:0] wb_read_data,
   output logic [4:0]  wb_write_reg,
   output logic        wb_regwrite,
   output logic [1:0]  wb_memtoreg,
   output logic [1:0]  wb_err
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              tmo_q, tmo_d;
   logic [31:0]       wb_pc_q, wb_pc_d;
   logic [31:0]       wb_alu_q, wb_alu_d;
   logic [31:0]       wb_rd_q, wb_rd_d;
   logic [4:0]        wb_wr_q, wb_wr_d;
   logic              wb_rw_q, wb_rw_d;
   logic [1:0]        wb_mtr_q, wb_mtr_d;
   logic [1:0]        wb_err_q, wb_err_d;
   logic              stall_c;
   logic              op, aligned, is_load;

   assign op      = ex_memread | ex_memwrite;
   assign aligned = (ex_alu_result[1:0] == 2'b00);
   // A combined read+write is treated as a store, so only pure reads return data.
   assign is_load = ex_memread & ~ex_memwrite;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      tmo_d     = tmo_q;
      wb_pc_d   = wb_pc_q;
      wb_alu_d  = wb_alu_q;
      wb_rd_d   = wb_rd_q;
      wb_wr_d   = wb_wr_q;
      wb_rw_d   = wb_rw_q;
      wb_mtr_d  = wb_mtr_q;
      wb_err_d  = wb_err_q;
      stall_c   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      case (state_q)
         IDLE: begin
            if (op && aligned) begin
               stall_c = 1'b1;
               state_d = ACCESS;
               cnt_d   = '0;
               tmo_d   = 1'b0;
               rdata_d = 32'd0;
            end else begin
               wb_pc_d  = ex_pc;
               wb_alu_d = ex_alu_result;
               wb_rd_d  = 32'd0;
               wb_wr_d  = ex_write_reg;
               wb_mtr_d = ex_memtoreg;
               wb_rw_d  = op ? 1'b0 : ex_regwrite;
               wb_err_d = op ? 2'b01 : 2'b00;
            end
         end
         ACCESS: begin
            stall_c   = 1'b1;
            mem_req   = 1'b1;
            mem_we    = ex_memwrite;
            mem_addr  = ex_alu_result;
            mem_wdata = ex_read_data2;
            // Ack is checked first so it wins over an expiring wait counter.
            if (mem_ack) begin
               rdata_d = is_load ? mem_rdata : 32'd0;
               state_d = COMPLETE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               tmo_d   = 1'b1;
               state_d = COMPLETE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         COMPLETE: begin
            wb_pc_d  = ex_pc;
            wb_alu_d = ex_alu_result;
            wb_wr_d  = ex_write_reg;
            wb_mtr_d = ex_memtoreg;
            wb_rw_d  = tmo_q ? 1'b0 : ex_regwrite;
            wb_rd_d  = tmo_q ? 32'd0 : rdata_q;
            wb_err_d = tmo_q ? 2'b10 : 2'b00;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset must drop the stall immediately even though the FSM sits in IDLE.
   assign stall = stall_c & reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rdata_q  <= 32'd0;
         tmo_q    <= 1'b0;
         wb_pc_q  <= 32'd0;
         wb_alu_q <= 32'd0;
         wb_rd_q  <= 32'd0;
         wb_wr_q  <= 5'd0;
         wb_rw_q  <= 1'b0;
         wb_mtr_q <= 2'd0;
         wb_err_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         tmo_q    <= tmo_d;
         wb_pc_q  <= wb_pc_d;
         wb_alu_q <= wb_alu_d;
         wb_rd_q  <= wb_rd_d;
         wb_wr_q  <= wb_wr_d;
         wb_rw_q  <= wb_rw_d;
         wb_mtr_q <= wb_mtr_d;
         wb_err_q <= wb_err_d;
      end
   end

   assign wb_pc         = wb_pc_q;
   assign wb_alu_result = wb_alu_q;
   assign wb_read_data  = wb_rd_q;
   assign wb_write_reg  = wb_wr_q;
   assign wb_regwrite   = wb_rw_q;
   assign wb_memtoreg   = wb_mtr_q;
   assign wb_err        = wb_err_q;

endmodule
